pcm_sample_reader: RTL and testbench

- Downstream consumer of the MP2 decoder's sample RAM, which is port B of the shared constant-ROM/sample-RAM BRAM.
- The polyphase synthesis stage writes 32 stereo PCM samples per bank into a ping-pong region. This block tracks which banks hold fresh data.
- On each audio-codec sample request it reads one left/right pair through an arbitrated port-B request/grant.
- It presents the pair to the AC97/DAC serializer and frees each bank once it has been consumed.

---
 rtl/pcm_sample_reader.sv | 186 ++++++++++++++++++
 tb/tb_pcm_sample_reader.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/pcm_sample_reader.sv
// pcm_sample_reader: pulls stereo PCM pairs out of the ping-pong sample RAM for the codec.
// Optional build macro PCM_MUTE_ON_UNDERRUN_EN: an underrun emits a valid 0/0 pair instead of holding.
module pcm_sample_reader #(
    parameter logic [9:0] BASE_ADDR = 10'h300,
    parameter int         BLOCK_LEN = 32
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        Block_Done_I,
    input  logic        Block_Bank_I,
    output logic [1:0]  Bank_Free_O,
    input  logic        Stereo_I,
    input  logic        Sample_Req_I,
    output logic        RAM_Req_O,
    input  logic        RAM_Grant_I,
    output logic [9:0]  RAM_Address_O,
    input  logic [15:0] RAM_Data_I,
    output logic [15:0] PCM_Left_O,
    output logic [15:0] PCM_Right_O,
    output logic        PCM_Valid_O,
    output logic        Underrun_O,
    output logic        Overflow_O
);

    localparam int              IDX_W    = $clog2(BLOCK_LEN);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_LEN - 1);
    localparam logic [9:0]      CH_OFS   = 10'(BLOCK_LEN);
    localparam logic [9:0]      BANK_OFS = 10'(2 * BLOCK_LEN);

    typedef enum logic [2:0] {
        IDLE,
        RD_L,
        CAP_L,
        RD_R,
        CAP_R,
        OUT
    } state_t;

    state_t           r_state;
    logic [1:0]       r_bank_valid;
    logic [1:0]       r_bank_free;
    logic             r_cur_bank;
    logic [IDX_W-1:0] r_idx;
    logic             r_pending;
    logic [15:0]      r_left_hold;
    logic             r_ram_req;
    logic [9:0]       r_ram_addr;
    logic [15:0]      r_pcm_left;
    logic [15:0]      r_pcm_right;
    logic             r_pcm_valid;
    logic             r_underrun;
    logic             r_overflow;

    logic             w_out_step;
    logic             w_bank_clear;
    logic [1:0]       w_bank_valid_nxt;
    logic             w_overflow;
    logic [9:0]       w_addr_left;

    // The output step is folded into the last capture cycle (CAP_L in mono, CAP_R in stereo).
    assign w_out_step   = ((r_state == CAP_L) && !Stereo_I) || (r_state == CAP_R);
    assign w_bank_clear = w_out_step && (r_idx == LAST_IDX);
    assign w_addr_left  = BASE_ADDR + (r_cur_bank ? BANK_OFS : 10'd0) + 10'(r_idx);

    // A refill landing on the edge that frees the bank wins and is not an overflow.
    always_comb begin
        w_bank_valid_nxt = r_bank_valid;
        w_overflow       = 1'b0;
        if (w_bank_clear) begin
            w_bank_valid_nxt[r_cur_bank] = 1'b0;
        end
        if (Block_Done_I) begin
            w_overflow = r_bank_valid[Block_Bank_I] &&
                         !(w_bank_clear && (r_cur_bank == Block_Bank_I));
            w_bank_valid_nxt[Block_Bank_I] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_bank_valid <= 2'b00;
            r_bank_free  <= 2'b11;
            r_overflow   <= 1'b0;
        end else begin
            r_bank_valid <= w_bank_valid_nxt;
            r_bank_free  <= ~w_bank_valid_nxt;
            r_overflow   <= w_overflow;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= IDLE;
            r_cur_bank  <= 1'b0;
            r_idx       <= '0;
            r_pending   <= 1'b0;
            r_left_hold <= 16'h0000;
            r_ram_req   <= 1'b0;
            r_ram_addr  <= 10'h000;
            r_pcm_left  <= 16'h0000;
            r_pcm_right <= 16'h0000;
            r_pcm_valid <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_pcm_valid <= 1'b0;
            r_underrun  <= 1'b0;
            if (Sample_Req_I && !r_pending) begin
                r_pending <= 1'b1;
            end
            unique case (r_state)
                IDLE: begin
                    if (r_pending) begin
                        r_pending <= 1'b0;
                        if (r_bank_valid[r_cur_bank]) begin
                            r_state    <= RD_L;
                            r_ram_req  <= 1'b1;
                            r_ram_addr <= w_addr_left;
                        end else begin
                            r_underrun <= 1'b1;
`ifdef PCM_MUTE_ON_UNDERRUN_EN
                            r_pcm_left  <= 16'h0000;
                            r_pcm_right <= 16'h0000;
                            r_pcm_valid <= 1'b1;
`endif
                        end
                    end
                end
                RD_L: begin
                    if (RAM_Grant_I) begin
                        r_ram_req <= 1'b0;
                        r_state   <= CAP_L;
                    end
                end
                CAP_L: begin
                    r_left_hold <= RAM_Data_I;
                    if (Stereo_I) begin
                        r_state    <= RD_R;
                        r_ram_req  <= 1'b1;
                        r_ram_addr <= r_ram_addr + CH_OFS;
                    end else begin
                        r_pcm_left  <= RAM_Data_I;
                        r_pcm_right <= RAM_Data_I;
                        r_pcm_valid <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                RD_R: begin
                    if (RAM_Grant_I) begin
                        r_ram_req <= 1'b0;
                        r_state   <= CAP_R;
                    end
                end
                CAP_R: begin
                    r_pcm_left  <= r_left_hold;
                    r_pcm_right <= RAM_Data_I;
                    r_pcm_valid <= 1'b1;
                    r_state     <= IDLE;
                end
                OUT: begin
                    r_state <= IDLE;
                end
                default: begin
                    r_state <= IDLE;
                end
            endcase
            if (w_out_step) begin
                if (r_idx == LAST_IDX) begin
                    r_idx      <= '0;
                    r_cur_bank <= ~r_cur_bank;
                end else begin
                    r_idx <= r_idx + 1'b1;
                end
            end
        end
    end

    assign Bank_Free_O   = r_bank_free;
    assign RAM_Req_O     = r_ram_req;
    assign RAM_Address_O = r_ram_addr;
    assign PCM_Left_O    = r_pcm_left;
    assign PCM_Right_O   = r_pcm_right;
    assign PCM_Valid_O   = r_pcm_valid;
    assign Underrun_O    = r_underrun;
    assign Overflow_O    = r_overflow;

endmodule

// File: tb/tb_pcm_sample_reader.sv
// tb_pcm_sample_reader: table vectors, directed corner cases and a randomized
// run against a bank/index model of the sample reader.
module tb_pcm_sample_reader;

    logic        clock;
    logic        reset;
    logic        Block_Done_I;
    logic        Block_Bank_I;
    logic [1:0]  Bank_Free_O;
    logic        Stereo_I;
    logic        Sample_Req_I;
    logic        RAM_Req_O;
    logic        RAM_Grant_I;
    logic [9:0]  RAM_Address_O;
    logic [15:0] RAM_Data_I;
    logic [15:0] PCM_Left_O;
    logic [15:0] PCM_Right_O;
    logic        PCM_Valid_O;
    logic        Underrun_O;
    logic        Overflow_O;

    pcm_sample_reader dut (
        .clock         (clock),
        .reset         (reset),
        .Block_Done_I  (Block_Done_I),
        .Block_Bank_I  (Block_Bank_I),
        .Bank_Free_O   (Bank_Free_O),
        .Stereo_I      (Stereo_I),
        .Sample_Req_I  (Sample_Req_I),
        .RAM_Req_O     (RAM_Req_O),
        .RAM_Grant_I   (RAM_Grant_I),
        .RAM_Address_O (RAM_Address_O),
        .RAM_Data_I    (RAM_Data_I),
        .PCM_Left_O    (PCM_Left_O),
        .PCM_Right_O   (PCM_Right_O),
        .PCM_Valid_O   (PCM_Valid_O),
        .Underrun_O    (Underrun_O),
        .Overflow_O    (Overflow_O)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Port-B sample RAM with one-cycle read latency after a granted address.
    logic [15:0] mem [0:1023];
    logic [15:0] ram_q;
    always @(posedge clock) begin
        if (RAM_Req_O && RAM_Grant_I) ram_q <= mem[RAM_Address_O];
    end
    assign RAM_Data_I = ram_q;

    int nvec;
    int nmis;

    // Reference model: which banks hold data, which bank/index plays next.
    logic [1:0]  mvalid;
    logic        mbank;
    int          midx;
    logic [15:0] lastL;
    logic [15:0] lastR;

    typedef struct {
        logic        st;
        int          stall;
        logic [15:0] el;
        logic [15:0] er;
        int          lat;
        logic [9:0]  ea;
    } vec_t;
    vec_t tbl [32];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic reset_dut();
        reset = 1'b1;
        @(negedge clock);
        chk("rst_free",  32'(Bank_Free_O), 32'h3);
        chk("rst_req",   32'(RAM_Req_O), 32'h0);
        chk("rst_addr",  32'(RAM_Address_O), 32'h0);
        chk("rst_valid", 32'(PCM_Valid_O), 32'h0);
        chk("rst_under", 32'(Underrun_O), 32'h0);
        chk("rst_ovf",   32'(Overflow_O), 32'h0);
        chk("rst_pcm",   {PCM_Left_O, PCM_Right_O}, 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;
        mvalid = 2'b00; mbank = 1'b0; midx = 0; lastL = '0; lastR = '0;
    endtask

    task automatic fill_bank(input logic b, input logic pattern);
        int base;
        base = 10'h300 + (b ? 64 : 0);
        for (int n = 0; n < 32; n++) begin
            mem[base + n]      = pattern ? 16'(n) : 16'($urandom);
            mem[base + 32 + n] = pattern ? 16'(16'h8000 + n) : 16'($urandom);
        end
    endtask

    task automatic pulse_done(input logic b, input logic exp_ovf);
        Block_Done_I = 1'b1;
        Block_Bank_I = b;
        @(posedge clock); #1;
        Block_Done_I = 1'b0;
        @(negedge clock);
        chk("overflow", 32'(Overflow_O), 32'(exp_ovf));
        @(posedge clock); #1;
        mvalid[b] = 1'b1;
    endtask

    // One request; grant withheld for 'stall' cycles of RD_L; optional Block_Done at cycle done_cyc.
    task automatic run_req(input string tag, input logic st, input int stall, input logic und,
                           input logic [15:0] el, input logic [15:0] er, input logic [9:0] ea,
                           input int elat, input int done_cyc, input logic dbank);
        int lat, ulat, bad, ovf;
        logic [15:0] gl, gr;
        lat = -1; ulat = -1; bad = 0; ovf = 0; gl = '0; gr = '0;
        Stereo_I = st;
        Sample_Req_I = 1'b1;
        for (int c = 0; c < elat + 2; c++) begin
            RAM_Grant_I  = !(c >= 2 && c < 2 + stall);
            Block_Done_I = (c == done_cyc);
            Block_Bank_I = dbank;
            @(negedge clock);
            if (RAM_Req_O && RAM_Address_O != ea && !(st && RAM_Address_O == ea + 10'd32)) bad++;
            if (PCM_Valid_O && lat < 0) begin lat = c; gl = PCM_Left_O; gr = PCM_Right_O; end
            if (Underrun_O && ulat < 0) ulat = c;
            if (Overflow_O) ovf++;
            @(posedge clock); #1;
            Sample_Req_I = 1'b0;
            Block_Done_I = 1'b0;
        end
        RAM_Grant_I = 1'b1;
        chk({tag, "_addr"}, 32'(bad), 32'h0);
        chk({tag, "_ovf"}, 32'(ovf), 32'h0);
        if (und) begin
            chk({tag, "_underrun_at"}, 32'(ulat), 32'd2);
`ifdef PCM_MUTE_ON_UNDERRUN_EN
            chk({tag, "_mute_lat"}, 32'(lat), 32'd2);
            chk({tag, "_mute_pair"}, {gl, gr}, {el, er});
`else
            chk({tag, "_no_valid"}, 32'(lat), 32'hFFFF_FFFF);
            chk({tag, "_held_pair"}, {PCM_Left_O, PCM_Right_O}, {el, er});
`endif
        end else begin
            chk({tag, "_latency"}, 32'(lat), 32'(elat));
            chk({tag, "_pair"}, {gl, gr}, {el, er});
            chk({tag, "_no_underrun"}, 32'(ulat), 32'hFFFF_FFFF);
        end
    endtask

    task automatic model_req(input logic st, input int stall, input int done_cyc, input logic dbank);
        logic [9:0]  a;
        logic [15:0] el, er;
        logic [1:0]  ef;
        logic        und;
        und = !mvalid[mbank];
        a = 10'h300 + (mbank ? 10'd64 : 10'd0) + 10'(midx);
        if (und) begin
`ifdef PCM_MUTE_ON_UNDERRUN_EN
            lastL = '0; lastR = '0;
`endif
            el = lastL; er = lastR;
        end else begin
            el = mem[a];
            er = st ? mem[a + 10'd32] : el;
            lastL = el; lastR = er;
        end
        run_req("model", st, stall, und, el, er, a, und ? 2 : (st ? 6 : 4) + stall, done_cyc, dbank);
        if (!und) begin
            midx++;
            if (midx == 32) begin
                midx = 0;
                mvalid[mbank] = 1'b0;
                mbank = ~mbank;
            end
        end
        if (done_cyc >= 0) mvalid[dbank] = 1'b1;
        ef = ~mvalid;
        chk("bank_free", 32'(Bank_Free_O), 32'(ef));
    endtask

    initial begin
        logic b;
        nvec = 0; nmis = 0;
        reset = 1'b1; Block_Done_I = 1'b0; Block_Bank_I = 1'b0;
        Stereo_I = 1'b1; Sample_Req_I = 1'b0; RAM_Grant_I = 1'b1;
        for (int i = 0; i < 1024; i++) mem[i] = '0;
        for (int n = 0; n < 32; n++) begin
            tbl[n].st    = !(n % 6 == 5);
            tbl[n].stall = (n == 0) ? 4 : ((n % 4 == 3) ? 2 : 0);
            tbl[n].el    = 16'(n);
            tbl[n].er    = tbl[n].st ? 16'(16'h8000 + n) : 16'(n);
            tbl[n].lat   = (tbl[n].st ? 6 : 4) + tbl[n].stall;
            tbl[n].ea    = 10'(10'h300 + n);
        end
        reset_dut();

        model_req(1'b1, 0, -1, 1'b0);

        fill_bank(1'b0, 1'b1);
        pulse_done(1'b0, 1'b0);
        pulse_done(1'b0, 1'b1);
        chk("free_bank0_full", 32'(Bank_Free_O), 32'h2);

        for (int n = 0; n < 32; n++) begin
            run_req("tbl", tbl[n].st, tbl[n].stall, 1'b0, tbl[n].el, tbl[n].er,
                    tbl[n].ea, tbl[n].lat, -1, 1'b0);
        end
        chk("free_after_32", 32'(Bank_Free_O), 32'h3);
        mvalid = 2'b00; mbank = 1'b1; midx = 0;
        lastL = tbl[31].el; lastR = tbl[31].er;
        model_req(1'b1, 0, -1, 1'b0);

        // Reset while the right-channel read is outstanding.
        reset_dut();
        fill_bank(1'b0, 1'b1);
        pulse_done(1'b0, 1'b0);
        Stereo_I = 1'b1; RAM_Grant_I = 1'b1; Sample_Req_I = 1'b1;
        @(posedge clock); #1;
        Sample_Req_I = 1'b0;
        repeat (3) begin @(posedge clock); #1; end
        chk("rdr_req", 32'(RAM_Req_O), 32'h1);
        chk("rdr_addr", 32'(RAM_Address_O), 32'h320);
        reset = 1'b1;
        #1;
        chk("midrst_req", 32'(RAM_Req_O), 32'h0);
        chk("midrst_free", 32'(Bank_Free_O), 32'h3);
        chk("midrst_valid", 32'(PCM_Valid_O), 32'h0);
        @(posedge clock); #1;
        reset = 1'b0;

        reset_dut();
        mem[10'h300] = 16'hFFFE;
        pulse_done(1'b0, 1'b0);
        model_req(1'b0, 0, -1, 1'b0);
        chk("mono_pair", {PCM_Left_O, PCM_Right_O}, 32'hFFFE_FFFE);

        // Ping-pong across both banks.
        reset_dut();
        fill_bank(1'b0, 1'b0);
        fill_bank(1'b1, 1'b0);
        mem[10'h340] = 16'h1234;
        pulse_done(1'b0, 1'b0);
        pulse_done(1'b1, 1'b0);
        for (int k = 0; k < 32; k++) model_req(1'b1, 0, -1, 1'b0);
        chk("pp_free_after_32", 32'(Bank_Free_O), 32'h1);
        model_req(1'b1, 0, -1, 1'b0);
        chk("pp_left_33", 32'(PCM_Left_O), 32'h1234);
        for (int k = 0; k < 30; k++) model_req(1'b1, 0, -1, 1'b0);
        // Refill of bank 1 lands on the edge that frees it.
        model_req(1'b1, 0, 5, 1'b1);
        chk("refill_keeps_valid", 32'(Bank_Free_O), 32'h1);

        for (int i = 0; i < 150; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                b = 1'($urandom_range(0, 1));
                if (!mvalid[b]) begin
                    fill_bank(b, 1'b0);
                    pulse_done(b, 1'b0);
                end else if ($urandom_range(0, 3) == 0) begin
                    pulse_done(b, 1'b1);
                end
            end
            model_req(1'($urandom_range(0, 1)), int'($urandom_range(0, 3)), -1, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
